// File: rtl/mem_arbiter.sv
// Two-port (I-cache / D-cache) arbiter onto one memory port: sticky registered grant with a
// burst limit, in-order read-response routing through an owner FIFO. Optional: MEM_ARB_RR_EN.
module mem_arbiter #(
    parameter int OUTSTANDING = 4,
    parameter int MAX_BURST   = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_imem_addr,
    input  logic        i_imem_ren,
    input  logic        i_imem_wen,
    input  logic [31:0] i_imem_wdata,
    output logic        o_imem_ready,
    output logic [31:0] o_imem_rdata,
    output logic        o_imem_valid,
    input  logic [31:0] i_dmem_addr,
    input  logic        i_dmem_ren,
    input  logic        i_dmem_wen,
    input  logic [31:0] i_dmem_wdata,
    output logic        o_dmem_ready,
    output logic [31:0] o_dmem_rdata,
    output logic        o_dmem_valid,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ready,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_valid,
    output logic        o_err_spurious
);
    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CW = $clog2(OUTSTANDING + 1);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, OWN_I = 2'd1, OWN_D = 2'd2} state_t;

    state_t          state_r, state_next_s, tie_s;
    logic [BW-1:0]   burst_cnt_r, burst_inc_s;
    logic [OUTSTANDING-1:0] fifo_id_r;   // 1 = response belongs to D
    logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            fifo_full_s, fifo_empty_s;
    logic            i_req_s, d_req_s, own_ren_s, own_wen_s;
    logic            accept_s, push_s, pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(OUTSTANDING - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    assign i_req_s      = i_imem_ren | i_imem_wen;
    assign d_req_s      = i_dmem_ren | i_dmem_wen;
    assign fifo_full_s  = (count_r == CW'(OUTSTANDING));
    assign fifo_empty_s = (count_r == {CW{1'b0}});
    assign push_s       = accept_s & own_ren_s;

`ifdef MEM_ARB_RR_EN
    logic last_grant_r;   // 1 = D was granted last

    assign tie_s = last_grant_r ? OWN_I : OWN_D;

    // Remember the most recent grant for the round-robin tie-break
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_grant_r <= 1'b0;
        end else if (state_next_s == OWN_I) begin
            last_grant_r <= 1'b0;
        end else if (state_next_s == OWN_D) begin
            last_grant_r <= 1'b1;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`else
    assign tie_s = OWN_D;
`endif

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state: the limit check counts an accept happening this cycle
    always_comb begin
        state_next_s = state_r;
        if (accept_s && (burst_cnt_r != BW'(MAX_BURST))) begin
            burst_inc_s = burst_cnt_r + BW'(1);
        end else begin
            burst_inc_s = burst_cnt_r;
        end
        case (state_r)
            IDLE: begin
                if (i_req_s && d_req_s) begin
                    state_next_s = tie_s;
                end else if (d_req_s) begin
                    state_next_s = OWN_D;
                end else if (i_req_s) begin
                    state_next_s = OWN_I;
                end else begin
                    state_next_s = IDLE;
                end
            end
            OWN_I: begin
                if (!i_req_s) begin
                    state_next_s = d_req_s ? OWN_D : IDLE;
                end else if ((burst_inc_s == BW'(MAX_BURST)) && d_req_s) begin
                    state_next_s = OWN_D;
                end else begin
                    state_next_s = OWN_I;
                end
            end
            OWN_D: begin
                if (!d_req_s) begin
                    state_next_s = i_req_s ? OWN_I : IDLE;
                end else if ((burst_inc_s == BW'(MAX_BURST)) && i_req_s) begin
                    state_next_s = OWN_I;
                end else begin
                    state_next_s = OWN_D;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Outputs: owner mux, accept handshake and response steering
    always_comb begin
        own_ren_s   = 1'b0;
        own_wen_s   = 1'b0;
        o_mem_addr  = 32'h0000_0000;
        o_mem_wdata = 32'h0000_0000;
        case (state_r)
            OWN_I: begin
                own_ren_s   = i_imem_ren;
                own_wen_s   = i_imem_wen;
                o_mem_addr  = i_imem_addr;
                o_mem_wdata = i_imem_wdata;
            end
            OWN_D: begin
                own_ren_s   = i_dmem_ren;
                own_wen_s   = i_dmem_wen;
                o_mem_addr  = i_dmem_addr;
                o_mem_wdata = i_dmem_wdata;
            end
            default: begin
                own_ren_s   = 1'b0;
                own_wen_s   = 1'b0;
                o_mem_addr  = 32'h0000_0000;
                o_mem_wdata = 32'h0000_0000;
            end
        endcase
        // A pop in the same cycle does not free a slot for a read
        o_mem_ren    = own_ren_s & ~fifo_full_s;
        o_mem_wen    = own_wen_s;
        accept_s     = i_mem_ready & (own_ren_s | own_wen_s) & ~(own_ren_s & fifo_full_s);
        o_imem_ready = accept_s & (state_r == OWN_I);
        o_dmem_ready = accept_s & (state_r == OWN_D);
        pop_s        = i_mem_valid & ~fifo_empty_s;
        o_imem_valid = pop_s & ~fifo_id_r[rd_ptr_r];
        o_dmem_valid = pop_s & fifo_id_r[rd_ptr_r];
        o_imem_rdata = i_mem_rdata;
        o_dmem_rdata = i_mem_rdata;
    end

    // Burst counter restarts on every ownership change
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            burst_cnt_r <= {BW{1'b0}};
        end else if (state_next_s != state_r) begin
            burst_cnt_r <= {BW{1'b0}};
        end else begin
            burst_cnt_r <= burst_inc_s;
        end
    end

    // Owner FIFO of outstanding reads
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fifo_id_r <= {OUTSTANDING{1'b0}};
            wr_ptr_r  <= {PW{1'b0}};
            rd_ptr_r  <= {PW{1'b0}};
            count_r   <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                fifo_id_r[wr_ptr_r] <= (state_r == OWN_D);
                wr_ptr_r            <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky flag for a response with nothing outstanding
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_err_spurious <= 1'b0;
        end else if (i_mem_valid && fifo_empty_s) begin
            o_err_spurious <= 1'b1;
        end else begin
            o_err_spurious <= o_err_spurious;
        end
    end
endmodule
